// File: rtl/score_keeper.sv
// Game score/timer: counts down per tick, penalises hole hits, freezes on a win.
// Optional best-score tracking and display mux: define SCORE_KEEPER_BEST_EN.
module score_keeper #(
  parameter int          TICK_CYCLES  = 100_000_000,
  parameter logic [15:0] START_SCORE  = 16'd9999,
  parameter logic [15:0] HOLE_PENALTY = 16'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        won_the_game,
  input  logic        hit_a_hole,
  input  logic        show_best,
  output logic [15:0] score,
  output logic [15:0] best_score,
  output logic        game_over,
  output logic        new_best,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_WON  = 2'b01,
    S_LOST = 2'b10
  } state_t;

  localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(TICK_CYCLES - 1);

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_cur, w_cur_nxt;
  logic [CW-1:0] r_tick_cnt, w_cnt_nxt;
  logic          r_win_q, r_hole_q;

  logic          w_win_p, w_hole_p, w_tick;
  logic [16:0]   w_dec;
  logic [15:0]   w_sub;

  assign w_win_p  = won_the_game & ~r_win_q;
  assign w_hole_p = hit_a_hole & ~r_hole_q;
  assign w_tick   = (r_state == S_RUN) && (r_tick_cnt == TICK_MAX);

  // 17-bit so tick + penalty never overflows before the saturating compare
  assign w_dec = {16'd0, w_tick}
               + (w_hole_p ? {1'b0, HOLE_PENALTY} : 17'd0);
  assign w_sub = ({1'b0, r_cur} > w_dec)
               ? (r_cur - w_dec[15:0]) : 16'd0;

`ifdef SCORE_KEEPER_BEST_EN
  logic [15:0] r_best, w_best_nxt;
  logic        r_new_best, w_nb_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_cnt_nxt   = r_tick_cnt;
`ifdef SCORE_KEEPER_BEST_EN
    w_best_nxt  = r_best;
    w_nb_nxt    = r_new_best;
`endif
    if (new_game) begin
      w_state_nxt = S_RUN;
      w_cur_nxt   = START_SCORE;
      w_cnt_nxt   = '0;
`ifdef SCORE_KEEPER_BEST_EN
      w_nb_nxt    = 1'b0;
`endif
    end else begin
      case (r_state)
        S_RUN: begin
          w_cnt_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
          if (w_win_p) begin
            w_state_nxt = S_WON;
`ifdef SCORE_KEEPER_BEST_EN
            if (r_cur > r_best) begin
              w_best_nxt = r_cur;
              w_nb_nxt   = 1'b1;
            end else begin
              w_nb_nxt   = 1'b0;
            end
`endif
          end else begin
            w_cur_nxt = w_sub;
            if (w_sub == 16'd0) w_state_nxt = S_LOST;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_cur      <= START_SCORE;
      r_tick_cnt <= '0;
      r_win_q    <= 1'b0;
      r_hole_q   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_tick_cnt <= w_cnt_nxt;
      r_win_q    <= won_the_game;
      r_hole_q   <= hit_a_hole;
    end
  end

`ifdef SCORE_KEEPER_BEST_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_best     <= 16'd0;
      r_new_best <= 1'b0;
    end else begin
      r_best     <= w_best_nxt;
      r_new_best <= w_nb_nxt;
    end
  end

  assign best_score = r_best;
  assign new_best   = r_new_best;
  assign score      = show_best ? r_best : r_cur;
`else
  assign best_score = 16'd0;
  assign new_best   = 1'b0;
  assign score      = r_cur;
`endif

  assign state     = r_state;
  assign game_over = (r_state != S_RUN);

endmodule

// File: tb/tb_score_keeper.sv
// Table-driven bench for score_keeper with an expected-result queue.
// Built with or without SCORE_KEEPER_BEST_EN; expectations adapt.
module tb_score_keeper;

`ifdef SCORE_KEEPER_BEST_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_game = 1'b0;
  logic        won_the_game = 1'b0;
  logic        hit_a_hole = 1'b0;
  logic        show_best = 1'b0;
  logic [15:0] score, best_score;
  logic        game_over, new_best;
  logic [1:0]  state;

  score_keeper #(
    .TICK_CYCLES (10),
    .START_SCORE (16'd100),
    .HOLE_PENALTY(16'd25)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .new_game    (new_game),
    .won_the_game(won_the_game),
    .hit_a_hole  (hit_a_hole),
    .show_best   (show_best),
    .score       (score),
    .best_score  (best_score),
    .game_over   (game_over),
    .new_best    (new_best),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, ng, win, hole, show;
    int          reps;
    logic [15:0] cur;
    logic [1:0]  st;
    logic [15:0] best;
    bit          nb;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] score;
    logic [1:0]  st;
    bit          go;
    logic [15:0] best;
    bit          nb;
  } exp_t;

  vec_t v[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(bit rst, bit ng, bit win, bit hole,
                              bit show, int reps, int cur, int st,
                              int best, bit nb);
    vec_t r;
    r.rst = rst; r.ng = ng; r.win = win; r.hole = hole;
    r.show = show; r.reps = reps; r.cur = 16'(cur);
    r.st = 2'(st); r.best = 16'(best); r.nb = nb;
    return r;
  endfunction

  task automatic chk(string nm, int idx, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    // rst ng win hole show reps cur st best nb
    v.push_back(mk(1,0,0,0,0, 2,100,0,  0,0));
    v.push_back(mk(0,0,0,0,0, 9,100,0,  0,0));
    v.push_back(mk(0,0,0,0,0, 1, 99,0,  0,0));
    v.push_back(mk(0,0,0,0,0,40, 95,0,  0,0));
    v.push_back(mk(0,0,0,1,0, 1, 70,0,  0,0));
    v.push_back(mk(0,0,0,1,0, 8, 70,0,  0,0));
    v.push_back(mk(0,0,0,1,0, 1, 69,0,  0,0));
    v.push_back(mk(0,0,0,1,0,30, 66,0,  0,0));
    v.push_back(mk(0,0,0,0,0, 1, 66,0,  0,0));
    v.push_back(mk(0,0,0,1,0, 1, 41,0,  0,0));
    v.push_back(mk(0,0,0,0,0, 1, 41,0,  0,0));
    v.push_back(mk(0,0,1,0,0, 1, 41,1, 41,1));
    v.push_back(mk(0,0,1,1,0,20, 41,1, 41,1));
    v.push_back(mk(0,0,0,0,0, 1, 41,1, 41,1));
    v.push_back(mk(0,0,0,0,1, 1, 41,1, 41,1));
    v.push_back(mk(0,1,1,0,0, 1,100,0, 41,0));
    v.push_back(mk(0,0,1,0,0,10, 99,0, 41,0));
    v.push_back(mk(0,0,0,0,0, 1, 99,0, 41,0));
    v.push_back(mk(0,0,1,0,0, 1, 99,1, 99,1));
    v.push_back(mk(0,1,0,0,0, 1,100,0, 99,0));
    v.push_back(mk(0,0,0,1,0, 1, 75,0, 99,0));
    v.push_back(mk(0,0,0,0,0, 1, 75,0, 99,0));
    v.push_back(mk(0,0,1,0,0, 1, 75,1, 99,0));
    v.push_back(mk(0,0,1,0,1, 1, 75,1, 99,0));
    v.push_back(mk(0,1,0,0,0, 1,100,0, 99,0));
    v.push_back(mk(0,0,1,1,0, 1,100,1,100,1));
    v.push_back(mk(0,1,0,0,0, 1,100,0,100,0));
    v.push_back(mk(0,0,1,0,0, 1,100,1,100,0));
    v.push_back(mk(0,1,0,0,0, 1,100,0,100,0));
    v.push_back(mk(0,0,0,0,0, 9,100,0,100,0));
    v.push_back(mk(0,0,0,1,0, 1, 74,0,100,0));
    v.push_back(mk(0,0,0,0,0, 1, 74,0,100,0));
    v.push_back(mk(0,0,0,1,0, 1, 49,0,100,0));
    v.push_back(mk(0,0,0,0,0, 1, 49,0,100,0));
    v.push_back(mk(0,0,0,1,0, 1, 24,0,100,0));
    v.push_back(mk(0,0,0,0,0, 1, 24,0,100,0));
    v.push_back(mk(0,0,0,1,0, 1,  0,2,100,0));
    v.push_back(mk(0,0,0,0,0, 1,  0,2,100,0));
    v.push_back(mk(0,0,0,1,0, 1,  0,2,100,0));
    v.push_back(mk(0,0,0,0,0,30,  0,2,100,0));
    v.push_back(mk(0,0,1,0,0, 1,  0,2,100,0));
    v.push_back(mk(0,1,0,0,0, 1,100,0,100,0));
    v.push_back(mk(0,0,0,1,0, 1, 75,0,100,0));
    v.push_back(mk(1,0,0,0,0, 1,100,0,  0,0));
    v.push_back(mk(0,0,0,0,0,10, 99,0,  0,0));

    foreach (v[i]) begin
      for (int r = 0; r < v[i].reps; r++) begin
        reset        = v[i].rst;
        new_game     = v[i].ng;
        won_the_game = v[i].win;
        hit_a_hole   = v[i].hole;
        show_best    = v[i].show;
        if (r == v[i].reps - 1) begin
          e.idx   = i;
          e.st    = v[i].st;
          e.go    = (v[i].st != 2'b00);
          e.best  = EN ? v[i].best : 16'd0;
          e.nb    = EN ? v[i].nb : 1'b0;
          e.score = (EN && v[i].show) ? v[i].best : v[i].cur;
          sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("score", e.idx, int'(score), int'(e.score));
          chk("state", e.idx, int'(state), int'(e.st));
          chk("game_over", e.idx, int'(game_over), int'(e.go));
          chk("best_score", e.idx, int'(best_score), int'(e.best));
          chk("new_best", e.idx, int'(new_best), int'(e.nb));
        end
      end
    end

    chk("sb_drain", -1, sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
